// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and forwarding controller for a classic 5-stage in-order pipeline.
// Decides, every cycle, which pipeline registers advance, which get cleared,
// and where the ALU operands in EX come from. It also tracks a stalled
// data-memory access, flags an access that never completes, and counts stall
// cycles for performance monitoring.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   id_rs, id_rt, id_usesRt       source registers of the instruction in ID
//   ex_rs, ex_rt, ex_wba          ID/EX sources and write-back address
//   ex_regWen, ex_MemtoReg        ID/EX write enable and load flag
//   mem_wba, mem_regWen           EX/MEM write-back
//   wb_wba, wb_regWen             MEM/WB write-back
//   branch_taken                  EX resolved a taken branch or jump
//   mem_req, mem_ready            data-memory access in MEM and its completion
//   if_en .. memwb_en             pipeline register enables
//   ifid_flush, idex_flush        synchronous clears for IF/ID and ID/EX
//   fwdA, fwdB                    operand select: 00 regfile, 01 WB, 10 MEM
//   mem_timeout                   sticky: memory wait exceeded 255 cycles
//   stall_cycles                  saturating count of stalled cycles
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_usesRt,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  ex_wba,
    input  logic        ex_regWen,
    input  logic        ex_MemtoReg,
    input  logic [4:0]  mem_wba,
    input  logic        mem_regWen,
    input  logic [4:0]  wb_wba,
    input  logic        wb_regWen,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        if_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    logic memhold;
    logic load_use;
    logic lu_stall;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Nearest producer wins: EX/MEM is younger than MEM/WB. Register 0 is
    // hard-wired zero, so a write to it never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] m_wba,
                                           input logic       m_wen,
                                           input logic [4:0] w_wba,
                                           input logic       w_wen);
        if (m_wen && (m_wba != 5'd0) && (m_wba == src))
            return 2'b10;
        else if (w_wen && (w_wba != 5'd0) && (w_wba == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        memhold  = (state_q == MEM_WAIT) || (mem_req && !mem_ready);
        load_use = ex_MemtoReg && ex_regWen && (ex_wba != 5'd0) &&
                   ((ex_wba == id_rs) || (id_usesRt && (ex_wba == id_rt)));
        // A taken branch squashes the dependent instruction anyway, so the
        // load-use bubble is only inserted when no branch is redirecting.
        lu_stall = load_use && !memhold && !branch_taken;
    end

    // Combinational pipeline control. Reset forces every stage to hold and
    // both front registers to clear so the pipe comes out of reset empty.
    always_comb begin
        if_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        fwdA       = 2'b00;
        fwdB       = 2'b00;
        if (reset) begin
            if_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            fwdA = fwd_sel(ex_rs, mem_wba, mem_regWen, wb_wba, wb_regWen);
            fwdB = fwd_sel(ex_rt, mem_wba, mem_regWen, wb_wba, wb_regWen);
            if (memhold) begin
                // Freeze the whole pipe; flushing here would lose work.
                if_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end else if (branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID, inject a bubble into ID/EX.
                if_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_timeout_d  = mem_timeout_q;
        stall_cycles_d = stall_cycles_q;
        case (state_q)
            RUN: begin
                // mem_ready without an outstanding request is meaningless.
                if (mem_req && !mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = sat_inc8(wait_cnt_q);
                    // Keep waiting after a timeout; the flag only reports it.
                    if (wait_cnt_q == 8'hFF)
                        mem_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
        if (memhold || lu_stall)
            stall_cycles_d = sat_inc16(stall_cycles_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            wait_cnt_q     <= 8'd0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench: a table of single-cycle vectors with hand-computed enables,
// flushes, forwarding selects and stall-counter increments, followed by
// hand-written sequences for memory waits, timeout and reset behaviour.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs, id_rt;
    logic        id_usesRt;
    logic [4:0]  ex_rs, ex_rt, ex_wba;
    logic        ex_regWen, ex_MemtoReg;
    logic [4:0]  mem_wba;
    logic        mem_regWen;
    logic [4:0]  wb_wba;
    logic        wb_regWen;
    logic        branch_taken;
    logic        mem_req, mem_ready;
    logic        if_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush;
    logic [1:0]  fwdA, fwdB;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    int n_vec  = 0;
    int n_miss = 0;

    pipeline_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_usesRt    (id_usesRt),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_wba       (ex_wba),
        .ex_regWen    (ex_regWen),
        .ex_MemtoReg  (ex_MemtoReg),
        .mem_wba      (mem_wba),
        .mem_regWen   (mem_regWen),
        .wb_wba       (wb_wba),
        .wb_regWen    (wb_regWen),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .if_en        (if_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .fwdA         (fwdA),
        .fwdB         (fwdB),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] id_rs, id_rt;
        logic       id_usesRt;
        logic [4:0] ex_rs, ex_rt, ex_wba;
        logic       ex_regWen, ex_MemtoReg;
        logic [4:0] mem_wba;
        logic       mem_regWen;
        logic [4:0] wb_wba;
        logic       wb_regWen;
        logic       br, req, rdy;
        logic [4:0] en;   // {if, ifid, idex, exmem, memwb}
        logic [1:0] fl;   // {ifid, idex}
        logic [1:0] fa, fb;
        logic       inc;  // expected stall_cycles increment
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic [4:0] a_id_rs, logic [4:0] a_id_rt, logic a_uses,
        logic [4:0] a_ex_rs, logic [4:0] a_ex_rt, logic [4:0] a_ex_wba,
        logic a_ex_wen, logic a_m2r,
        logic [4:0] a_mem_wba, logic a_mem_wen,
        logic [4:0] a_wb_wba, logic a_wb_wen,
        logic a_br, logic a_req, logic a_rdy,
        logic [4:0] a_en, logic [1:0] a_fl, logic [1:0] a_fa, logic [1:0] a_fb,
        logic a_inc);
        vec_t v;
        v.id_rs = a_id_rs;   v.id_rt = a_id_rt;   v.id_usesRt = a_uses;
        v.ex_rs = a_ex_rs;   v.ex_rt = a_ex_rt;   v.ex_wba = a_ex_wba;
        v.ex_regWen = a_ex_wen; v.ex_MemtoReg = a_m2r;
        v.mem_wba = a_mem_wba; v.mem_regWen = a_mem_wen;
        v.wb_wba = a_wb_wba; v.wb_regWen = a_wb_wen;
        v.br = a_br; v.req = a_req; v.rdy = a_rdy;
        v.en = a_en; v.fl = a_fl; v.fa = a_fa; v.fb = a_fb; v.inc = a_inc;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        id_rs = v.id_rs; id_rt = v.id_rt; id_usesRt = v.id_usesRt;
        ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_wba = v.ex_wba;
        ex_regWen = v.ex_regWen; ex_MemtoReg = v.ex_MemtoReg;
        mem_wba = v.mem_wba; mem_regWen = v.mem_regWen;
        wb_wba = v.wb_wba; wb_regWen = v.wb_regWen;
        branch_taken = v.br; mem_req = v.req; mem_ready = v.rdy;
    endtask

    task automatic idle();
        apply(mk(0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,0,0, 5'b11111,2'b00,2'b00,2'b00,0));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] ens();
        return {if_en, ifid_en, idex_en, exmem_en, memwb_en};
    endfunction

    function automatic logic [1:0] fls();
        return {ifid_flush, idex_flush};
    endfunction

    logic [15:0] s0;

    initial begin
        // ---------------- table ----------------
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,0,0, 5'b11111,2'b00,2'b00,2'b00,0)); // idle
        vecs.push_back(mk(5,6,1, 1,2,5,1,1, 0,0, 0,0, 0,0,0, 5'b00111,2'b01,2'b00,2'b00,1)); // load-use rs
        vecs.push_back(mk(0,6,1, 1,2,0,1,1, 0,0, 0,0, 0,0,0, 5'b11111,2'b00,2'b00,2'b00,0)); // wba=0=rs
        vecs.push_back(mk(3,9,1, 1,2,9,1,1, 0,0, 0,0, 0,0,0, 5'b00111,2'b01,2'b00,2'b00,1)); // load-use rt
        vecs.push_back(mk(3,9,0, 1,2,9,1,1, 0,0, 0,0, 0,0,0, 5'b11111,2'b00,2'b00,2'b00,0)); // rt unused
        vecs.push_back(mk(5,6,1, 1,2,5,1,0, 0,0, 0,0, 0,0,0, 5'b11111,2'b00,2'b00,2'b00,0)); // not a load
        vecs.push_back(mk(5,6,1, 1,2,5,0,1, 0,0, 0,0, 0,0,0, 5'b11111,2'b00,2'b00,2'b00,0)); // no regWen
        vecs.push_back(mk(5,6,1, 1,2,5,1,1, 0,0, 0,0, 1,0,0, 5'b11111,2'b11,2'b00,2'b00,0)); // branch+LU
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0, 0,0, 1,0,0, 5'b11111,2'b11,2'b00,2'b00,0)); // branch
        vecs.push_back(mk(0,0,0, 7,0,0,0,0, 7,1, 7,1, 0,0,0, 5'b11111,2'b00,2'b10,2'b00,0)); // MEM wins
        vecs.push_back(mk(0,0,0, 7,0,0,0,0, 3,1, 7,1, 0,0,0, 5'b11111,2'b00,2'b01,2'b00,0)); // WB only
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1, 0,1, 0,0,0, 5'b11111,2'b00,2'b00,2'b00,0)); // r0
        vecs.push_back(mk(0,0,0, 4,12,0,0,0, 12,1, 4,1, 0,0,0, 5'b11111,2'b00,2'b01,2'b10,0)); // A=WB B=MEM
        vecs.push_back(mk(0,0,0, 7,7,0,0,0, 7,0, 7,1, 0,0,0, 5'b11111,2'b00,2'b01,2'b01,0)); // MEM no wen
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,0,1, 5'b11111,2'b00,2'b00,2'b00,0)); // rdy w/o req
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,1,1, 5'b11111,2'b00,2'b00,2'b00,0)); // req done
        vecs.push_back(mk(5,6,1, 5,2,5,1,1, 5,1, 0,0, 0,0,0, 5'b00111,2'b01,2'b10,2'b00,1)); // LU + fwd
        vecs.push_back(mk(0,0,0, 0,9,0,0,0, 0,0, 9,1, 0,0,0, 5'b11111,2'b00,2'b00,2'b01,0)); // B WB only

        // ---------------- reset state ----------------
        idle();
        ex_rs = 5'd7; mem_wba = 5'd7; mem_regWen = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en", ens(), 5'b00000);
        check("rst_flush", fls(), 2'b11);
        check("rst_fwdA", fwdA, 2'b00);
        check("rst_timeout", mem_timeout, 1'b0);
        check("rst_stall", stall_cycles, 16'd0);
        idle();
        reset = 1'b0;
        @(posedge clk); #1;

        // ---------------- table loop ----------------
        foreach (vecs[i]) begin
            apply(vecs[i]);
            s0 = stall_cycles;
            @(negedge clk);
            check($sformatf("v%0d_en", i), ens(), vecs[i].en);
            check($sformatf("v%0d_flush", i), fls(), vecs[i].fl);
            check($sformatf("v%0d_fwdA", i), fwdA, vecs[i].fa);
            check($sformatf("v%0d_fwdB", i), fwdB, vecs[i].fb);
            @(posedge clk); #1;
            check($sformatf("v%0d_stall", i), stall_cycles, s0 + 16'(vecs[i].inc));
        end

        // ---------------- memory wait: 3 low cycles then ready ----------------
        idle();
        s0 = stall_cycles;
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mem_ready    = (c == 3);
            branch_taken = (c == 1);
            @(negedge clk);
            check($sformatf("mw%0d_en", c), ens(), 5'b00000);
            check($sformatf("mw%0d_flush", c), fls(), 2'b00);
            @(posedge clk); #1;
        end
        idle();
        check("mw_stall", stall_cycles, s0 + 16'd4);
        @(negedge clk);
        check("mw_run_en", ens(), 5'b11111);
        @(posedge clk); #1;

        // ---------------- timeout ----------------
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int e = 1; e <= 300; e++) begin
            @(posedge clk); #1;
            if (e == 255) check("to_before", mem_timeout, 1'b0);
            if (e == 256) check("to_rise", mem_timeout, 1'b1);
        end
        check("to_sticky", mem_timeout, 1'b1);
        check("to_hold_en", ens(), 5'b00000);
        mem_req = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        check("to_after_ready", mem_timeout, 1'b1);
        check("to_run_en", ens(), 5'b11111);
        #2 reset = 1'b1;
        #1;
        check("to_rst_clear", mem_timeout, 1'b0);
        check("to_rst_stall", stall_cycles, 16'd0);
        @(posedge clk); #1;
        idle();
        reset = 1'b0;
        #1;
        check("to_rel_en", ens(), 5'b11111);

        // ---------------- reset mid-wait ----------------
        @(posedge clk); #1;
        mem_req = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_req = 1'b0;
        check("rw_wait_en", ens(), 5'b00000);
        #2 reset = 1'b1;
        #1;
        check("rw_rst_en", ens(), 5'b00000);
        check("rw_rst_flush", fls(), 2'b11);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rw_run_en", ens(), 5'b11111);
        @(posedge clk); #1;
        check("rw_run_en2", ens(), 5'b11111);
        check("rw_stall", stall_cycles, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
